imem_bank: RTL and testbench
============================

# imem_bank

Parametrised, byte-addressed instruction/program memory with a registered read port, a valid/ready request-response handshake, byte-enable writes and range/alignment error reporting. It sits between the fetch stage (or the program loader) and the storage array. It replaces the fixed 32-byte combinational-read store with a single-cycle-latency, back-pressurable memory. An optional power-up clear sequence zero-fills the array after reset.

## Interface
- ADDRWIDTH, 32, byte-address width.
- DATAWIDTH, 32, word width in bits; multiple of 8, power of two, ≥ 16.
- START_ADDR, 32'h0, byte address of word 0; aligned to DATAWIDTH/8.
- MEM_DEPTH, 1024, capacity in bytes; a multiple of DATAWIDTH/8.
- CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = contents persist across reset (initial-block preload allowed).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_addr  in  ADDRWIDTH  byte address.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  DATAWIDTH/8  byte enables for writes; ignored on reads.
- req_wdata  in  DATAWIDTH  write data; little-endian, byte i = bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  DATAWIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  request was out of range or misaligned.

## Operation
- Storage: MEM_DEPTH/(DATAWIDTH/8) words. Word index = (req_addr − START_ADDR) >> log2(DATAWIDTH/8).
- State machine: INIT, RUN.
  - Reset enters INIT if CLEAR_ON_RESET=1, otherwise RUN.
  - INIT writes zero to one word per cycle, starting at index 0, with req_ready=0.
  - After the last word is written, INIT moves to RUN.
- Acceptance: accept = req_valid & req_ready. In RUN, req_ready = !rsp_valid | rsp_ready.
- Error check: a request is an error if req_addr < START_ADDR, or req_addr > START_ADDR+MEM_DEPTH−1, or the low log2(DATAWIDTH/8) address bits are nonzero.
  - An error request sets rsp_err=1 and rsp_rdata=0.
  - An error write must not modify the array.
- Read: rsp_rdata is the word at the index, captured at the acceptance edge.
- Write: at the acceptance edge, only bytes with req_be[i]=1 are updated. Response has rsp_rdata=0 and rsp_err=0. req_be=0 is a legal no-op that still responds.
- Read-after-write: a read accepted in the cycle after a write to the same word returns the updated bytes.
- Response register holds rsp_valid, rsp_rdata and rsp_err stable while rsp_valid & !rsp_ready. No new request is accepted during that time.
- Reset asserted mid-operation:
  - Drops any pending response.
  - Restarts INIT from word 0 when CLEAR_ON_RESET=1.
  - An in-flight write accepted at the same edge as reset assertion is not guaranteed.

## Timing
- Reset values: req_ready=0 (INIT) or 1 (RUN), rsp_valid=0, rsp_rdata=0, rsp_err=0, INIT index=0.
- Latency: request accepted at edge N → rsp_valid=1 after edge N, i.e. one cycle.
- Throughput: one request per cycle while rsp_ready stays high.
- INIT duration: exactly MEM_DEPTH/(DATAWIDTH/8) cycles after rst_n deasserts. req_ready rises in the following cycle.
- Simultaneous response consumption and new acceptance in the same cycle: rsp_valid stays 1 and the fields update to the new response.
- rsp_valid falls after an edge where rsp_valid & rsp_ready & !accept.
- req_ready depends combinationally on rsp_ready. No other combinational path exists from inputs to outputs.

## Test plan
- Reset clear: CLEAR_ON_RESET=1, MEM_DEPTH=1024, DATAWIDTH=32.
  - Expect req_ready=0 for 256 cycles after rst_n rises.
  - Then a read of 0x3FC returns 0x00000000, rsp_err=0.
- Write/read back: write 0x00940333 to 0x0 with req_be=4'hF, then read 0x0 in the next cycle.
  - The read response 1 cycle after acceptance is 0x00940333.
- Byte enables: word 0x8 holds 0x035A02B3; write 0xFFFFFFFF with req_be=4'b0101.
  - Read of 0x8 returns 0x03FF02FF.
- Errors: read 0x2 (misaligned) and read 0x400 (out of range) each give rsp_err=1, rsp_rdata=0.
  - Write 0xDEADBEEF to 0x400 leaves every word unchanged.
- Back-pressure: issue reads to 0x0, 0x4, 0x8 back-to-back with rsp_ready=0 for 3 cycles.
  - rsp_rdata holds the 0x0 data and req_ready=0 during the stall.
  - After rsp_ready rises, the three responses arrive in order, one per cycle.
- Mid-operation reset: pull rst_n low while rsp_valid=1 and in INIT.
  - rsp_valid drops immediately.
  - INIT restarts, and a full 256-cycle clear precedes req_ready=1.

Source files
------------

// File: rtl/imem_bank.sv
// imem_bank: byte-addressed program memory with a registered read port,
// valid/ready request/response handshake, byte-enable writes, range and
// alignment error reporting, and an optional zero-fill sequence after reset.
module imem_bank #(
  parameter int unsigned           ADDRWIDTH      = 32,
  parameter int unsigned           DATAWIDTH      = 32,
  parameter logic [ADDRWIDTH-1:0]  START_ADDR     = '0,
  parameter int unsigned           MEM_DEPTH      = 1024,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRWIDTH-1:0]     req_addr,
  input  logic                     req_we,
  input  logic [DATAWIDTH/8-1:0]   req_be,
  input  logic [DATAWIDTH-1:0]     req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATAWIDTH-1:0]     rsp_rdata,
  output logic                     rsp_err
);

  localparam int unsigned BYTES = DATAWIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned WORDS = MEM_DEPTH / BYTES;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [ADDRWIDTH:0]   DEPTH_L  = (ADDRWIDTH + 1)'(MEM_DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_e                 state_q;
  logic [IDX_W-1:0]       init_idx_q;
  logic                   rsp_valid_q;
  logic [DATAWIDTH-1:0]   rsp_rdata_q;
  logic                   rsp_err_q;
  logic [DATAWIDTH-1:0]   mem_q [WORDS];

  logic [ADDRWIDTH-1:0]   offset;
  logic [ADDRWIDTH:0]     offset_ext;
  logic [IDX_W-1:0]       idx;
  logic                   req_err;
  logic                   accept;
  logic                   wr_en;

  // Address decode: word index plus range/alignment error flag.
  always_comb begin
    offset     = req_addr - START_ADDR;
    offset_ext = {1'b0, offset};
    idx        = offset[OFF_W +: IDX_W];
    req_err    = (req_addr < START_ADDR) || (offset_ext >= DEPTH_L) ||
                 (|req_addr[OFF_W-1:0]);
  end

  // Requests are held off during the clear and while a response is stalled.
  assign req_ready = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_we && !req_err;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Control FSM: zero-fill one word per cycle, then serve requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      init_idx_q <= '0;
    end else if (state_q == ST_INIT) begin
      if (init_idx_q == LAST_IDX) begin
        state_q <= ST_RUN;
      end else begin
        init_idx_q <= init_idx_q + IDX_W'(1);
      end
    end
  end

  // Storage array: clear writes during INIT, byte-enable writes in RUN.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[init_idx_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_be[b]) mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // Response register: loads on accept, holds under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= (req_we || req_err) ? '0 : mem_q[idx];
      rsp_err_q   <= req_err;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_bank.sv
// Directed self-checking bench for imem_bank with default parameters.
module tb_imem_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // One request with rsp_ready high; returns the response sampled one cycle later.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output logic vld);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL req_accept_timeout addr=%h got req_ready=%b want 1", addr, req_ready);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    rd = rsp_rdata; er = rsp_err; vld = rsp_valid;
  endtask

  // Release reset just after an edge and count cycles until req_ready rises.
  task automatic release_and_count(output int cnt);
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && cnt < 1000) begin cnt++; @(negedge clk); end
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_be = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_tests++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    release_and_count(cnt);
    n_tests++; if (cnt != 256) begin n_fail++; $display("FAIL init_duration got %0d want 256", cnt); end
  endtask

  task automatic test_clear_read();
    logic [31:0] rd; logic er, vld;
    do_req(1'b0, 32'h3FC, 4'h0, 32'h0, rd, er, vld);
    n_tests++; if (vld !== 1'b1 || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL clear_read_3fc got v=%b d=%h e=%b want v=1 d=00000000 e=0", vld, rd, er); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er, vld;
    do_req(1'b1, 32'h0, 4'hF, 32'h00940333, rd, er, vld);
    n_tests++; if (vld !== 1'b1 || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL write_rsp got v=%b d=%h e=%b want v=1 d=0 e=0", vld, rd, er); end
    do_req(1'b0, 32'h0, 4'h0, 32'h0, rd, er, vld);
    n_tests++; if (rd !== 32'h00940333 || er !== 1'b0) begin
      n_fail++; $display("FAIL readback_0 got d=%h e=%b want 00940333 e=0", rd, er); end
    do_req(1'b1, 32'h4, 4'hF, 32'h12345678, rd, er, vld);
    do_req(1'b0, 32'h4, 4'h0, 32'h0, rd, er, vld);
    n_tests++; if (rd !== 32'h12345678) begin
      n_fail++; $display("FAIL readback_4 got %h want 12345678", rd); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er, vld;
    do_req(1'b1, 32'h8, 4'hF, 32'h035A02B3, rd, er, vld);
    do_req(1'b1, 32'h8, 4'b0101, 32'hFFFFFFFF, rd, er, vld);
    do_req(1'b0, 32'h8, 4'h0, 32'h0, rd, er, vld);
    n_tests++; if (rd !== 32'h03FF02FF) begin
      n_fail++; $display("FAIL byte_enable got %h want 03FF02FF", rd); end
    do_req(1'b1, 32'h8, 4'h0, 32'h00000000, rd, er, vld);
    n_tests++; if (vld !== 1'b1 || er !== 1'b0) begin
      n_fail++; $display("FAIL be_zero_rsp got v=%b e=%b want v=1 e=0", vld, er); end
    do_req(1'b0, 32'h8, 4'h0, 32'h0, rd, er, vld);
    n_tests++; if (rd !== 32'h03FF02FF) begin
      n_fail++; $display("FAIL be_zero_noop got %h want 03FF02FF", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, vld;
    do_req(1'b0, 32'h2, 4'h0, 32'h0, rd, er, vld);
    n_tests++; if (vld !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL misaligned_read got v=%b e=%b d=%h want v=1 e=1 d=0", vld, er, rd); end
    do_req(1'b0, 32'h400, 4'h0, 32'h0, rd, er, vld);
    n_tests++; if (vld !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL range_read got v=%b e=%b d=%h want v=1 e=1 d=0", vld, er, rd); end
    do_req(1'b1, 32'h400, 4'hF, 32'hDEADBEEF, rd, er, vld);
    n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL range_write_rsp got e=%b d=%h want e=1 d=0", er, rd); end
    do_req(1'b1, 32'h6, 4'hF, 32'hDEADBEEF, rd, er, vld);
    do_req(1'b0, 32'h0, 4'h0, 32'h0, rd, er, vld);
    n_tests++; if (rd !== 32'h00940333) begin
      n_fail++; $display("FAIL err_write_word0 got %h want 00940333", rd); end
    do_req(1'b0, 32'h4, 4'h0, 32'h0, rd, er, vld);
    n_tests++; if (rd !== 32'h12345678) begin
      n_fail++; $display("FAIL err_write_word4 got %h want 12345678", rd); end
    do_req(1'b0, 32'h3FC, 4'h0, 32'h0, rd, er, vld);
    n_tests++; if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL err_write_last got d=%h e=%b want 0 e=0", rd, er); end
  endtask

  // Write followed by a read of the same word in the very next cycle.
  task automatic test_back_to_back();
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
    req_be = 4'hF; req_wdata = 32'hA5A5C3C3;
    @(posedge clk); #1 req_we = 1'b0; req_be = 4'h0;
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_write_rsp got v=%b d=%h rdy=%b want v=1 d=0 rdy=1", rsp_valid, rsp_rdata, req_ready); end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5C3C3) begin
      n_fail++; $display("FAIL raw_read got v=%b d=%h want v=1 d=A5A5C3C3", rsp_valid, rsp_rdata); end
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rsp_drop got v=%b want 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_be = 4'h0;
    @(posedge clk); #1 req_addr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00940333 || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold cyc=%0d got v=%b d=%h rdy=%b want v=1 d=00940333 rdy=0",
                           i, rsp_valid, rsp_rdata, req_ready); end
    end
    rsp_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_follows_rsp_ready got %b want 1", req_ready); end
    @(posedge clk); #1 req_addr = 32'h8;
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL bp_rsp2 got v=%b d=%h want v=1 d=12345678", rsp_valid, rsp_rdata); end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h03FF02FF) begin
      n_fail++; $display("FAIL bp_rsp3 got v=%b d=%h want v=1 d=03FF02FF", rsp_valid, rsp_rdata); end
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain got v=%b want 0", rsp_valid); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] rd; logic er, vld;
    int cnt;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_valid got %b want 1", rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_drop got v=%b d=%h rdy=%b want 0 0 0", rsp_valid, rsp_rdata, req_ready); end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    release_and_count(cnt);
    n_tests++; if (cnt != 256) begin
      n_fail++; $display("FAIL init_restart_duration got %0d want 256", cnt); end
    do_req(1'b0, 32'h0, 4'h0, 32'h0, rd, er, vld);
    n_tests++; if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL cleared_word0 got d=%h e=%b want 0 e=0", rd, er); end
    do_req(1'b0, 32'h10, 4'h0, 32'h0, rd, er, vld);
    n_tests++; if (rd !== 32'h0) begin
      n_fail++; $display("FAIL cleared_word10 got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_clear_read();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
